times_table_sweeper: RTL

- Sequencer and checker that sits around the times-table memory: it drives a/b/enable into the multiplier, and consumes its registered result.
- On a start pulse it sweeps all 64 operand pairs (a outer, b inner), tracks the memory's read latency, and compares each returned product against the arithmetic a*b.
- It publishes each checked product on a valid strobe and keeps an error count for the whole sweep.
- Used as a built-in self-test and as the stimulus/collection stage for the table.

---
 rtl/times_table_sweeper.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/times_table_sweeper.sv
// Sweeps all 64 operand pairs through the times-table memory, tracks the read
// latency with a tag pipeline and checks every returned product against a*b.
module times_table_sweeper #(
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    output logic [2:0] a_out,
    output logic [2:0] b_out,
    output logic       enable,
    input  logic [5:0] result_in,
    output logic       prod_valid,
    output logic [2:0] prod_a,
    output logic [2:0] prod_b,
    output logic [5:0] prod_value,
    output logic       prod_err,
    output logic [6:0] error_count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [5:0] index;
    logic [5:0] index_next;
    logic       issue;
    logic       clear_count;

    // One stage per cycle of memory latency; the last stage lines up with result_in.
    logic [RD_LATENCY-1:0]      tag_valid;
    logic [RD_LATENCY-1:0][5:0] tag_ab;

    logic       in_flight;
    logic       sample;
    logic [5:0] sample_ab;
    logic [5:0] expected;
    logic       mismatch;

    assign in_flight = |tag_valid;
    assign sample    = tag_valid[RD_LATENCY-1];
    assign sample_ab = tag_ab[RD_LATENCY-1];
    assign expected  = {3'b000, sample_ab[5:3]} * {3'b000, sample_ab[2:0]};
    assign mismatch  = (result_in != expected);

    // NOTE: every variable written here gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        index_next  = index;
        issue       = 1'b0;
        clear_count = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next  = S_ISSUE;
                    index_next  = '0;
                    clear_count = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!hold) begin
                    issue      = 1'b1;
                    index_next = index + 6'd1;
                    if (index == 6'd63) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!in_flight) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operands come straight from the index register; enable is qualified by the
    // registered ISSUE state so a hold cycle suppresses the read in that same cycle.
    assign a_out  = index[5:3];
    assign b_out  = index[2:0];
    assign enable = issue;
    assign busy   = (state == S_ISSUE) || (state == S_DRAIN);
    assign done   = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            index <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
        end
    end

    // Reset clears the tags so reads in flight at reset never produce a strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_ab    <= '0;
        end else begin
            tag_valid[0] <= issue;
            tag_ab[0]    <= index;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_ab[i]    <= tag_ab[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_valid <= 1'b0;
            prod_a     <= '0;
            prod_b     <= '0;
            prod_value <= '0;
            prod_err   <= 1'b0;
        end else begin
            prod_valid <= sample;
            if (sample) begin
                prod_a     <= sample_ab[5:3];
                prod_b     <= sample_ab[2:0];
                prod_value <= result_in;
                prod_err   <= mismatch;
            end
        end
    end

    // Count is bumped on the same edge that raises prod_valid for a bad product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_count <= '0;
        end else if (clear_count) begin
            error_count <= '0;
        end else if (sample && mismatch) begin
            error_count <= error_count + 7'd1;
        end
    end

endmodule
